// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and helpers for the pipelined carry-lookahead adder
package cla_pkg;

    localparam int CLA_WIDTH = 24;
    localparam int CLA_GROUP = 6;

    function automatic bit width_ok(input int width, input int group);
        return (group > 0) && (width > 0) && ((width % group) == 0);
    endfunction

    // Signed extremes of a width-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice
module cla_group #(
    parameter int GROUP = 6
) (
    input  logic [GROUP-1:0] x,
    input  logic [GROUP-1:0] y,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p = x ^ y;
    assign g = x & y;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s        = p ^ c[GROUP-1:0];
    assign co       = c[GROUP];
    assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA add/sub, one lookahead group per stage
// Optional clamp on signed overflow: PIPELINED_CLA_SATURATE_EN
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int L       = NGROUPS - 1;

    if (!width_ok(WIDTH, GROUP)) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // Stage j holds finished sum bits below j*GROUP in acc_q and the still
    // unprocessed A bits above; y_q keeps only the unprocessed B bits.
    for (genvar j = 0; j < NGROUPS; j++) begin : g_stage
        localparam int LO = j * GROUP;
        localparam int YW = WIDTH - LO;

        logic             vld_q, vld_d;
        logic             c_q, c_d;
        logic [WIDTH-1:0] acc_q, acc_d;
        logic [YW-1:0]    y_q, y_d;
        logic [GROUP-1:0] grp_s;
        logic             grp_co;

        if (j == 0) begin : g_in
            assign vld_d = in_valid;
            assign acc_d = a;
            assign y_d   = sub ? ~b : b;
            assign c_d   = sub | cin;
        end else begin : g_link
            always_comb begin
                acc_d = g_stage[j-1].acc_q;
                acc_d[LO-GROUP +: GROUP] = g_stage[j-1].grp_s;
            end
            assign y_d   = g_stage[j-1].y_q[YW+GROUP-1:GROUP];
            assign vld_d = g_stage[j-1].vld_q;
            assign c_d   = g_stage[j-1].grp_co;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
                y_q   <= '0;
            end else if (advance) begin
                vld_q <= vld_d;
                c_q   <= c_d;
                acc_q <= acc_d;
                y_q   <= y_d;
            end
        end

        if (j == L) begin : g_last
            logic cm;
            cla_group #(.GROUP(GROUP)) u_grp (
                .x        (acc_q[LO +: GROUP]),
                .y        (y_q[GROUP-1:0]),
                .ci       (c_q),
                .s        (grp_s),
                .co       (grp_co),
                .c_msb_in (cm)
            );
        end else begin : g_mid
            logic cm_unused;
            cla_group #(.GROUP(GROUP)) u_grp (
                .x        (acc_q[LO +: GROUP]),
                .y        (y_q[GROUP-1:0]),
                .ci       (c_q),
                .s        (grp_s),
                .co       (grp_co),
                .c_msb_in (cm_unused)
            );
        end
    end

    logic [WIDTH-1:0] res_wrap;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    always_comb begin
        res_wrap = g_stage[L].acc_q;
        res_wrap[WIDTH-1 -: GROUP] = g_stage[L].grp_s;
    end

    assign ovf_d = g_stage[L].g_last.cm ^ g_stage[L].grp_co;

`ifdef PIPELINED_CLA_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    // On overflow both effective operands share the MSB; A's MSB picks the side.
    assign res_d = !ovf_d ? res_wrap
                 : (g_stage[L].acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
    assign res_d = res_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= g_stage[L].vld_q;
            if (g_stage[L].vld_q) begin
                sum_q  <= res_d;
                cout_q <= g_stage[L].grp_co;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
